ram_arbiter: RTL and testbench
==============================

# ram_arbiter

Two-port arbiter sharing the core's 256x4 external RAM between the CPU data port (STO/LOAD) and a loader/debug port (serial bootloader or test DMA). The CPU always wins a contended cycle; the loader is served in free cycles through a req/gnt handshake. An optional starvation guard briefly freezes the CPU so the loader is guaranteed to progress. The block sits between the core's RAM pins and the RAM macro at the top level.

## Interface
- AW, 8: RAM address width.
- DW, 4: RAM data width.
- STARVE_LIM, 8: loader wait cycles before a CPU hold is forced (range 2..15).

- clk  in  1  clock; all state on the rising edge.
- nreset  in  1  reset, asynchronous, active-low.
- cpu_addr  in  AW  CPU RAM address ({R7,R6}).
- cpu_wdata  in  DW  CPU write data.
- cpu_we  in  1  CPU write strobe (registered STO).
- cpu_rd  in  1  CPU read in progress (LOAD decode, already gated by top with !cpu_hold).
- cpu_rdata  out  DW  RAM read data to CPU, equal to ram_rdata.
- lp_req  in  1  loader request; held with lp_we/addr/wdata stable until lp_gnt.
- lp_we  in  1  1 = write, 0 = read.
- lp_addr  in  AW  loader address.
- lp_wdata  in  DW  loader write data.
- lp_gnt  out  1  combinational grant; the access happens in this cycle.
- lp_rvalid  out  1  registered one-cycle pulse after a granted read.
- lp_rdata  out  DW  registered read data, valid with lp_rvalid and held until the next read.
- cpu_hold  out  1  registered request to freeze the CPU (drives core tm_en with tm_inc_pc=0).
- ram_addr  out  AW  RAM address.
- ram_wdata  out  DW  RAM write data.
- ram_we  out  1  RAM write enable; RAM writes on rising edge.
- ram_rdata  in  DW  RAM asynchronous read data.

## Operation
- cpu_busy = (cpu_we | cpu_rd) & !cpu_hold.
- Grant: lp_gnt = lp_req & !cpu_busy.
- Mux, combinational:
  - When lp_gnt=1, ram_addr/ram_wdata come from the loader and ram_we = lp_we.
  - Otherwise they come from the CPU and ram_we = cpu_we & !cpu_hold.
- Read return: on a clock edge where lp_gnt=1 and lp_we=0, lp_rdata <= ram_rdata and lp_rvalid is 1 in the next cycle. Back-to-back loader grants are allowed, one access per cycle.
- FSM, 3 states:
  - IDLE: no pending loader request.
    - lp_req & !lp_gnt -> WAIT.
    - Otherwise stay in IDLE.
  - WAIT: loader blocked by the CPU. wait_cnt increments each blocked cycle.
    - lp_gnt -> IDLE and wait_cnt clears.
    - wait_cnt == STARVE_LIM-1 while still blocked -> HOLD.
  - HOLD: cpu_hold=1, so cpu_busy=0 and the loader is granted this cycle. The state always returns to IDLE next cycle and wait_cnt clears.
- If lp_req drops while in WAIT (protocol violation), the FSM returns to IDLE and wait_cnt clears.
- cpu_we is masked during HOLD. The CPU is frozen and issues none, but the mask makes sure no CPU write leaks.

## Timing
- Reset values: lp_rvalid=0, lp_rdata=0, cpu_hold=0, state=IDLE, wait_cnt=0.
- Reset values of combinational outputs (all inputs idle): lp_gnt=0, ram_we=0, ram_addr=cpu_addr.
- Latency:
  - Loader write: 0 extra cycles when the port is free. RAM is written at the edge that ends the lp_gnt cycle.
  - Loader read: lp_rvalid follows one cycle after lp_gnt.
- Worst-case loader wait with the guard: STARVE_LIM+1 cycles from lp_req to lp_gnt.
- cpu_hold is high for exactly one cycle per starvation event. It goes high the cycle after wait_cnt reaches STARVE_LIM-1.
- Simultaneous cpu_we and lp_req: the CPU write wins and the loader waits. No data is lost on either side.
- Reset asserted mid-read: lp_rvalid is not issued and the pending request is dropped. The loader must re-request after reset.

## Configuration
- RAM_ARB_STARVE_EN defined: wait_cnt, the HOLD state and cpu_hold are present as described.
- RAM_ARB_STARVE_EN undefined:
  - The FSM has IDLE and WAIT only, with no counter.
  - cpu_hold is tied to 0 and cpu_busy = cpu_we | cpu_rd.
  - The loader may starve indefinitely under a continuous CPU access stream.

## Structure
- Shared package ram_arb_pkg holds:
  - the state enum (IDLE=2'd0, WAIT=2'd1, HOLD=2'd2);
  - the default AW/DW values;
  - the STARVE_LIM default.
- Sub-module ram_arb_starve_cnt contains the saturating wait counter and the cpu_hold register. It is instantiated only under RAM_ARB_STARVE_EN.
- The datapath mux stays in ram_arbiter.

## Test plan
- Idle CPU; loader writes addr 0x3C data 0xA, then reads 0x3C -> lp_gnt in the same cycle as each request, lp_rvalid one cycle after the read, lp_rdata=0xA.
- cpu_we=1 at addr 0x10 data 0x5 while lp_req writes 0x10 data 0x9 -> lp_gnt=0 that cycle and the CPU write lands. Loader granted next cycle; final RAM[0x10]=0x9.
- CPU read 0x20 while a loader read of 0x21 is pending -> cpu_rdata=RAM[0x20]. Loader granted on the first cycle without cpu_rd; lp_rdata=RAM[0x21].
- With RAM_ARB_STARVE_EN and STARVE_LIM=8, cpu_rd held high and lp_req asserted -> cpu_hold pulses for 1 cycle exactly 8 cycles after lp_req, lp_gnt=1 in that cycle, then the FSM returns to IDLE.
- Without RAM_ARB_STARVE_EN, the same stimulus for 100 cycles -> cpu_hold stays 0 and lp_gnt stays 0.
- nreset pulsed in the cycle between a loader read grant and lp_rvalid -> lp_rvalid stays 0, lp_rdata=0, state=IDLE.

Source files
------------

// File: rtl/ram_arb_pkg.sv
// Shared types and defaults for the RAM arbiter slice.
package ram_arb_pkg;

    // Arbiter FSM states; HOLD is reachable only with the starvation guard built in.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
    } arb_state_t;

    // Default geometry of the core's external RAM (256 x 4).
    localparam int unsigned RAM_AW = 8;
    localparam int unsigned RAM_DW = 4;

    // Default loader wait, in blocked cycles, before the CPU is frozen.
    localparam int unsigned RAM_STARVE_LIM = 8;

endpackage

// File: rtl/ram_arb_starve_cnt.sv
// Loader starvation guard: counts blocked loader cycles and registers the
// one-cycle CPU freeze request. Used by ram_arbiter only when
// RAM_ARB_STARVE_EN is defined.
module ram_arb_starve_cnt
    import ram_arb_pkg::*;
#(
    parameter int unsigned STARVE_LIM = RAM_STARVE_LIM
) (
    input  logic clk,
    input  logic nreset,
    input  logic blocked,    // loader requesting but not granted this cycle
    input  logic clr,        // FSM heads back to IDLE
    input  logic hold_next,  // FSM heads to HOLD
    output logic at_lim,     // wait_cnt has reached STARVE_LIM-1
    output logic cpu_hold
);

    logic [3:0] wait_cnt;

    // Saturating count of consecutive blocked loader cycles.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of block ordering.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            wait_cnt <= '0;
        end else if (clr) begin
            wait_cnt <= '0;
        end else if (blocked && (wait_cnt != 4'hF)) begin
            wait_cnt <= wait_cnt + 4'd1;
        end
    end

    // Freeze request is high exactly in the cycle the FSM sits in HOLD.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            cpu_hold <= 1'b0;
        end else begin
            cpu_hold <= hold_next;
        end
    end

    assign at_lim = (wait_cnt == 4'(STARVE_LIM - 1));

endmodule

// File: rtl/ram_arbiter.sv
// Two-port arbiter for the core's external RAM: the CPU data port always wins,
// the loader/debug port is served in free cycles via lp_req/lp_gnt.
// Optional starvation guard: define RAM_ARB_STARVE_EN to add the wait counter,
// the HOLD state and the cpu_hold freeze request.
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int unsigned AW         = RAM_AW,
    parameter int unsigned DW         = RAM_DW,
    parameter int unsigned STARVE_LIM = RAM_STARVE_LIM
) (
    input  logic          clk,
    input  logic          nreset,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    input  logic          cpu_we,
    input  logic          cpu_rd,
    output logic [DW-1:0] cpu_rdata,
    input  logic          lp_req,
    input  logic          lp_we,
    input  logic [AW-1:0] lp_addr,
    input  logic [DW-1:0] lp_wdata,
    output logic          lp_gnt,
    output logic          lp_rvalid,
    output logic [DW-1:0] lp_rdata,
    output logic          cpu_hold,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_wdata,
    output logic          ram_we,
    input  logic [DW-1:0] ram_rdata
);

    arb_state_t state_q;
    arb_state_t state_d;
    logic       cpu_busy;
    logic       at_lim;

    // A frozen CPU gives up the port, which is what lets the loader through.
    assign cpu_busy = (cpu_we | cpu_rd) & ~cpu_hold;
    assign lp_gnt   = lp_req & ~cpu_busy;

    // Datapath mux: the granted loader owns the RAM pins, otherwise the CPU,
    // whose writes are masked while it is frozen.
    assign ram_addr  = lp_gnt ? lp_addr  : cpu_addr;
    assign ram_wdata = lp_gnt ? lp_wdata : cpu_wdata;
    assign ram_we    = lp_gnt ? lp_we    : (cpu_we & ~cpu_hold);
    assign cpu_rdata = ram_rdata;

`ifdef RAM_ARB_STARVE_EN
    logic blocked;

    assign blocked = lp_req & ~lp_gnt;

    ram_arb_starve_cnt #(
        .STARVE_LIM (STARVE_LIM)
    ) u_starve_cnt (
        .clk       (clk),
        .nreset    (nreset),
        .blocked   (blocked),
        .clr       (state_d == IDLE),
        .hold_next (state_d == HOLD),
        .at_lim    (at_lim),
        .cpu_hold  (cpu_hold)
    );
`else
    logic [3:0] starve_lim_unused;

    // Without the guard the loader simply waits for a free cycle.
    assign starve_lim_unused = 4'(STARVE_LIM);
    assign at_lim            = 1'b0;
    assign cpu_hold          = 1'b0;
`endif

    // FSM state register.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: track a loader request that the CPU keeps blocking.
    // NOTE: state_d is defaulted before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (lp_req && !lp_gnt) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (lp_gnt || !lp_req) begin
                    state_d = IDLE;
                end else if (at_lim) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Loader read return: capture RAM data at the end of a granted read.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            lp_rvalid <= 1'b0;
            lp_rdata  <= '0;
        end else begin
            lp_rvalid <= lp_gnt & ~lp_we;
            if (lp_gnt && !lp_we) begin
                lp_rdata <= ram_rdata;
            end
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter with a behavioural RAM and reference
// model. Builds with or without RAM_ARB_STARVE_EN.
module tb_ram_arbiter;
    import ram_arb_pkg::*;

    localparam int AW         = 8;
    localparam int DW         = 4;
    localparam int STARVE_LIM = 8;
`ifdef RAM_ARB_STARVE_EN
    localparam bit STARVE_EN = 1'b1;
`else
    localparam bit STARVE_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          nreset;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_we;
    logic          cpu_rd;
    logic [DW-1:0] cpu_rdata;
    logic          lp_req;
    logic          lp_we;
    logic [AW-1:0] lp_addr;
    logic [DW-1:0] lp_wdata;
    logic          lp_gnt;
    logic          lp_rvalid;
    logic [DW-1:0] lp_rdata;
    logic          cpu_hold;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic          ram_we;
    logic [DW-1:0] ram_rdata;

    int vectors     = 0;
    int miscompares = 0;

    // RAM macro stand-in and the bench's own expected contents.
    logic [DW-1:0] mem     [256];
    logic [DW-1:0] ref_mem [256];

    // Reference model state.
    logic          m_rvalid;
    logic [DW-1:0] m_rdata;
    int            m_run;   // consecutive blocked loader cycles so far

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
    end
    assign ram_rdata = mem[ram_addr];

    ram_arbiter #(
        .AW (AW), .DW (DW), .STARVE_LIM (STARVE_LIM)
    ) dut (
        .clk (clk), .nreset (nreset),
        .cpu_addr (cpu_addr), .cpu_wdata (cpu_wdata), .cpu_we (cpu_we),
        .cpu_rd (cpu_rd), .cpu_rdata (cpu_rdata),
        .lp_req (lp_req), .lp_we (lp_we), .lp_addr (lp_addr),
        .lp_wdata (lp_wdata), .lp_gnt (lp_gnt), .lp_rvalid (lp_rvalid),
        .lp_rdata (lp_rdata), .cpu_hold (cpu_hold),
        .ram_addr (ram_addr), .ram_wdata (ram_wdata), .ram_we (ram_we),
        .ram_rdata (ram_rdata)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle with the current inputs: check every output against the
    // model at the falling edge, advance the model, return just after the
    // rising edge. Reports the DUT's observed grant/hold for that cycle.
    task automatic step(output logic g_obs, output logic h_obs);
        logic          hold;
        logic          busy;
        logic          gnt;
        logic          wr;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        @(negedge clk);
        hold = STARVE_EN && (m_run == STARVE_LIM);
        busy = (cpu_we | cpu_rd) & !hold;
        gnt  = lp_req & !busy;
        a    = gnt ? lp_addr  : cpu_addr;
        d    = gnt ? lp_wdata : cpu_wdata;
        wr   = gnt ? lp_we    : (cpu_we & !hold);
        check("lp_gnt",    lp_gnt,    gnt);
        check("cpu_hold",  cpu_hold,  hold);
        check("ram_we",    ram_we,    wr);
        check("ram_addr",  ram_addr,  a);
        check("ram_wdata", ram_wdata, d);
        check("cpu_rdata", cpu_rdata, ref_mem[a]);
        check("lp_rvalid", lp_rvalid, m_rvalid);
        check("lp_rdata",  lp_rdata,  m_rdata);
        g_obs = lp_gnt;
        h_obs = cpu_hold;
        if (gnt && !lp_we) m_rdata = ref_mem[a];
        m_rvalid = gnt & !lp_we;
        if (wr) ref_mem[a] = d;
        m_run = hold ? 0 : ((lp_req && !gnt) ? m_run + 1 : 0);
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_idle();
        cpu_we = 1'b0; cpu_rd = 1'b0; cpu_wdata = '0;
    endtask

    task automatic lp_set(input logic req, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        lp_req = req; lp_we = we; lp_addr = a; lp_wdata = d;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic g;
        logic h;
        int   first_gnt;
        int   first_hold;
        int   n_gnt;
        int   n_hold;

        for (int i = 0; i < 256; i++) begin
            mem[i]     = 4'($urandom);
            ref_mem[i] = mem[i];
        end
        m_rvalid = 1'b0; m_rdata = '0; m_run = 0;

        // Reset state with idle inputs.
        nreset = 1'b0;
        cpu_idle();
        cpu_addr = 8'h55;
        lp_set(1'b0, 1'b0, 8'h00, 4'h0);
        #12;
        check("rst_lp_rvalid", lp_rvalid, 1'b0);
        check("rst_lp_rdata",  lp_rdata,  4'h0);
        check("rst_cpu_hold",  cpu_hold,  1'b0);
        check("rst_lp_gnt",    lp_gnt,    1'b0);
        check("rst_ram_we",    ram_we,    1'b0);
        check("rst_ram_addr",  ram_addr,  8'h55);
        check("rst_state",     dut.state_q, IDLE);
        @(posedge clk); #1;
        nreset = 1'b1;

        // Loader write then read of 0x3C with an idle CPU.
        lp_set(1'b1, 1'b1, 8'h3C, 4'hA);
        step(g, h);
        check("tp1_wr_gnt", g, 1'b1);
        lp_set(1'b1, 1'b0, 8'h3C, 4'h0);
        step(g, h);
        check("tp1_rd_gnt", g, 1'b1);
        lp_set(1'b0, 1'b0, 8'h00, 4'h0);
        check("tp1_rvalid", lp_rvalid, 1'b1);
        check("tp1_rdata",  lp_rdata,  4'hA);
        step(g, h);

        // Simultaneous CPU write and loader write to 0x10.
        cpu_addr = 8'h10; cpu_wdata = 4'h5; cpu_we = 1'b1;
        lp_set(1'b1, 1'b1, 8'h10, 4'h9);
        step(g, h);
        check("tp2_blocked", g, 1'b0);
        check("tp2_cpu_wr",  mem[8'h10], 4'h5);
        cpu_idle();
        step(g, h);
        check("tp2_gnt", g, 1'b1);
        lp_set(1'b0, 1'b0, 8'h00, 4'h0);
        check("tp2_final", mem[8'h10], 4'h9);

        // CPU read of 0x20 while a loader read of 0x21 waits.
        cpu_addr = 8'h20; cpu_rd = 1'b1;
        lp_set(1'b1, 1'b0, 8'h21, 4'h0);
        step(g, h);
        check("tp3_blk0", g, 1'b0);
        step(g, h);
        check("tp3_blk1", g, 1'b0);
        cpu_rd = 1'b0;
        step(g, h);
        check("tp3_gnt", g, 1'b1);
        lp_set(1'b0, 1'b0, 8'h00, 4'h0);
        check("tp3_rdata", lp_rdata, mem[8'h21]);
        step(g, h);

        // Continuous CPU reads against a pending loader read.
        cpu_addr = 8'h30; cpu_rd = 1'b1;
        lp_set(1'b1, 1'b0, 8'h31, 4'h0);
        first_gnt = -1; first_hold = -1; n_gnt = 0; n_hold = 0;
        for (int i = 0; i < 100; i++) begin
            step(g, h);
            if (g) n_gnt++;
            if (h) n_hold++;
            if (g && first_gnt < 0)  first_gnt  = i;
            if (h && first_hold < 0) first_hold = i;
            if (STARVE_EN && g) break;
        end
        if (STARVE_EN) begin
            check("tp4_gnt_cycle",  first_gnt,  STARVE_LIM);
            check("tp4_hold_cycle", first_hold, STARVE_LIM);
            check("tp4_hold_count", n_hold, 1);
            lp_set(1'b0, 1'b0, 8'h00, 4'h0);
            check("tp4_state_idle", dut.state_q, IDLE);
            step(g, h);
            check("tp4_hold_gone", h, 1'b0);
        end else begin
            check("tp4_no_gnt",  n_gnt,  0);
            check("tp4_no_hold", n_hold, 0);
            lp_set(1'b0, 1'b0, 8'h00, 4'h0);
            step(g, h);
        end
        cpu_idle();
        step(g, h);

        // Reset pulsed between a loader read grant and its rvalid.
        lp_set(1'b1, 1'b0, 8'h3C, 4'h0);
        @(negedge clk);
        check("tp5_gnt", lp_gnt, 1'b1);
        nreset = 1'b0;
        @(posedge clk); #1;
        lp_set(1'b0, 1'b0, 8'h00, 4'h0);
        nreset = 1'b1;
        m_rvalid = 1'b0; m_rdata = '0; m_run = 0;
        check("tp5_rvalid", lp_rvalid, 1'b0);
        check("tp5_rdata",  lp_rdata,  4'h0);
        check("tp5_state",  dut.state_q, IDLE);
        step(g, h);

        // Randomized traffic on a small address window to force collisions.
        for (int i = 0; i < 400; i++) begin
            cpu_we    = ($urandom_range(0, 3) == 0);
            cpu_rd    = !cpu_we && ($urandom_range(0, 2) == 0);
            cpu_addr  = {5'b01000, 3'($urandom)};
            cpu_wdata = 4'($urandom);
            if (!lp_req && ($urandom_range(0, 1) == 1)) begin
                lp_set(1'b1, 1'($urandom), {5'b01000, 3'($urandom)}, 4'($urandom));
            end
            step(g, h);
            if (g) lp_req = 1'b0;
        end
        cpu_idle();
        lp_set(1'b0, 1'b0, 8'h00, 4'h0);
        step(g, h);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
